regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core, the successor to the single-cycle register file. It provides NR combinational read ports and two prioritised write ports: W0 for ALU writeback and W1 for load/long-latency writeback. It has optional write-to-read bypass and a per-register pending-write scoreboard. It also has a registered debug read port for the simulation monitor. Register 0 is hardwired to zero throughout.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, 5, register index width; must equal log2(NREG)
NR, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_id_i  in  NR*AW  read indices, port k at bits [k*AW +: AW]
rd_data_o  out  NR*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy_o  out  NR  port k register has a pending write
w0_en_i  in  1  write port 0 enable
w0_id_i  in  AW  write port 0 index
w0_data_i  in  XLEN  write port 0 data
w1_en_i  in  1  write port 1 enable (higher priority)
w1_id_i  in  AW  write port 1 index
w1_data_i  in  XLEN  write port 1 data
sb_set_i  in  1  issue: mark sb_id_i pending
sb_id_i  in  AW  register to mark pending
dbg_id_i  in  AW  debug read index
dbg_data_o  out  XLEN  debug read data, registered
busy_vec_o  out  NREG  full scoreboard vector, bit i = reg i pending

Behaviour:
- Reset is asynchronous on rst_n low. All registers, the scoreboard, and dbg_data_o go to 0 immediately. Reset mid-operation discards any write in that cycle. Release is sampled on the next clk edge.
- Writes are applied at posedge. A write with id 0 is ignored. If w0 and w1 target the same nonzero id in the same cycle, w1 data is stored and w0 is dropped. Different ids are both stored.
- Reads are combinational. Index 0 returns 0 and busy 0.
- If BYPASS=1 and the read index is nonzero and matches an active write this cycle, rd_data_o returns the write data (w1 over w0). rd_busy_o for that port reads 0 unless sb_set_i targets the same id this cycle.
- If BYPASS=0, a read returns the pre-edge stored value and the registered busy bit.
- Scoreboard, per register i at posedge: next = set_i | (busy_i & ~clr_i).
  - clr_i is asserted when either write port writes i.
  - set_i is asserted when sb_set_i is high and sb_id_i == i, i != 0.
  - Set beats clear in the same cycle, so a new issue overlaps the old writeback.
  - A set on a register already busy leaves it busy.
  - Bit 0 is always 0.
- busy_vec_o reflects the registered scoreboard with no bypass.
- dbg_data_o is loaded at each posedge with the stored value of dbg_id_i, giving 1-cycle latency. A same-cycle write is not reflected. dbg_id_i = 0 yields 0.
- An index >= NREG cannot occur because AW = log2(NREG). Writes to register NREG-1 must work, as the top index boundary.

Test Plan:
- Reset: write reg 5 = 0xDEADBEEF, assert rst_n low asynchronously between edges -> rd_data(5)=0, busy_vec_o=0, dbg_data_o=0 immediately.
- x0 and port conflict:
  - w0 writes reg 0 = 0x1234 -> read 0 returns 0.
  - w0 (id 7, 0xAAAA0000) and w1 (id 7, 0x5555) in the same cycle -> reg 7 = 0x5555 next cycle.
- Bypass, BYPASS=1: w0 writes reg 3 = 0xCAFEF00D while port 1 reads 3 -> rd_data same cycle = 0xCAFEF00D.
  - Repeat with BYPASS=0 -> old value, then 0xCAFEF00D next cycle.
- Scoreboard: sb_set id 9 -> busy_vec_o[9]=1 next cycle. w1 writes 9 -> bit clears next cycle.
  - sb_set id 9 together with w0 writing 9 -> bit stays 1.
- Debug port: write reg 31 = 0x0BADC0DE, next cycle set dbg_id_i=31 -> dbg_data_o = 0x0BADC0DE one edge later. Reg 31 also confirms the top-index write.
- Parameter sweep: NR=3, NREG=16, AW=4, XLEN=64; random writes and reads over 1000 cycles are checked against a reference model, including read index 15 and three simultaneous reads.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NR combinational reads, two prioritised write
// ports (W1 over W0), optional write-to-read bypass, pending-write scoreboard, debug port.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NR*AW-1:0]     rd_id_i,
  output logic [NR*XLEN-1:0]   rd_data_o,
  output logic [NR-1:0]        rd_busy_o,
  input  logic                 w0_en_i,
  input  logic [AW-1:0]        w0_id_i,
  input  logic [XLEN-1:0]      w0_data_i,
  input  logic                 w1_en_i,
  input  logic [AW-1:0]        w1_id_i,
  input  logic [XLEN-1:0]      w1_data_i,
  input  logic                 sb_set_i,
  input  logic [AW-1:0]        sb_id_i,
  input  logic [AW-1:0]        dbg_id_i,
  output logic [XLEN-1:0]      dbg_data_o,
  output logic [NREG-1:0]      busy_vec_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] dbg_data_q;
  logic            w0_act;
  logic            w1_act;

  // Writes to x0 are squashed here so nothing downstream has to re-check index 0.
  assign w0_act = w0_en_i && (w0_id_i != '0);
  assign w1_act = w1_en_i && (w1_id_i != '0);

  always_comb begin
    busy_d = '0;
    wr_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      wr_hit[i] = (w0_act && (w0_id_i == AW'(i))) || (w1_act && (w1_id_i == AW'(i)));
      // A new issue wins over a completing writeback to the same register.
      busy_d[i] = (sb_set_i && (sb_id_i == AW'(i))) || (busy_q[i] && !wr_hit[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      dbg_data_q <= '0;
    end else begin
      if (w0_act && !(w1_act && (w1_id_i == w0_id_i))) regs_q[w0_id_i] <= w0_data_i;
      if (w1_act) regs_q[w1_id_i] <= w1_data_i;
      busy_q     <= busy_d;
      dbg_data_q <= regs_q[dbg_id_i];
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0]   id;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] data;
    logic            busy;

    assign id   = rd_id_i[gi*AW +: AW];
    assign hit1 = (BYPASS != 0) && w1_act && (w1_id_i == id);
    assign hit0 = (BYPASS != 0) && w0_act && (w0_id_i == id);

    always_comb begin
      data = regs_q[id];
      busy = busy_q[id];
      if (id == '0) begin
        data = '0;
        busy = 1'b0;
      end else if (hit1) begin
        data = w1_data_i;
        busy = sb_set_i && (sb_id_i == id);
      end else if (hit0) begin
        data = w0_data_i;
        busy = sb_set_i && (sb_id_i == id);
      end
    end

    assign rd_data_o[gi*XLEN +: XLEN] = data;
    assign rd_busy_o[gi]              = busy;
  end

  assign dbg_data_o = dbg_data_q;
  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: BYPASS=1 and BYPASS=0 instances on shared stimulus, plus a
// 16x64 three-read-port instance swept randomly against a reference model.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [9:0]  rd_id;
  logic        w0_en, w1_en, sb_set;
  logic [4:0]  w0_id, w1_id, sb_id, dbg_id;
  logic [31:0] w0_data, w1_data;
  logic [63:0] a_rd, b_rd;
  logic [1:0]  a_busy, b_busy;
  logic [31:0] a_dbg, b_dbg, a_vec, b_vec;

  logic [11:0]  c_rd_id;
  logic         c_w0_en, c_w1_en, c_sb_set;
  logic [3:0]   c_w0_id, c_w1_id, c_sb_id, c_dbg_id;
  logic [63:0]  c_w0_data, c_w1_data, c_dbg;
  logic [191:0] c_rd;
  logic [2:0]   c_busy;
  logic [15:0]  c_vec;

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_id_i(rd_id), .rd_data_o(a_rd), .rd_busy_o(a_busy),
    .w0_en_i(w0_en), .w0_id_i(w0_id), .w0_data_i(w0_data),
    .w1_en_i(w1_en), .w1_id_i(w1_id), .w1_data_i(w1_data),
    .sb_set_i(sb_set), .sb_id_i(sb_id), .dbg_id_i(dbg_id), .dbg_data_o(a_dbg), .busy_vec_o(a_vec));

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NR(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_id_i(rd_id), .rd_data_o(b_rd), .rd_busy_o(b_busy),
    .w0_en_i(w0_en), .w0_id_i(w0_id), .w0_data_i(w0_data),
    .w1_en_i(w1_en), .w1_id_i(w1_id), .w1_data_i(w1_data),
    .sb_set_i(sb_set), .sb_id_i(sb_id), .dbg_id_i(dbg_id), .dbg_data_o(b_dbg), .busy_vec_o(b_vec));

  regfile_mp #(.XLEN(64), .NREG(16), .AW(4), .NR(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_id_i(c_rd_id), .rd_data_o(c_rd), .rd_busy_o(c_busy),
    .w0_en_i(c_w0_en), .w0_id_i(c_w0_id), .w0_data_i(c_w0_data),
    .w1_en_i(c_w1_en), .w1_id_i(c_w1_id), .w1_data_i(c_w1_data),
    .sb_set_i(c_sb_set), .sb_id_i(c_sb_id), .dbg_id_i(c_dbg_id), .dbg_data_o(c_dbg), .busy_vec_o(c_vec));

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [63:0] m_reg [16];
  logic [15:0] m_busy;

  task automatic idle();
    w0_en = 0; w1_en = 0; sb_set = 0;
    w0_id = 0; w1_id = 0; sb_id = 0;
    w0_data = 0; w1_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); rd_id = {5'd0, 5'd5}; dbg_id = 5;
    w0_en = 1; w0_id = 5; w0_data = 32'hDEADBEEF; sb_set = 1; sb_id = 5;
    tick(); idle(); tick();
    sbq.push_back('{"pre_reset_rd5", 64'hDEADBEEF});
    sbq.push_back('{"pre_reset_busy5", 64'd1});
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[31:0], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(a_vec[5]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_vec[5], e.exp); end
    #2 rst_n = 0; #1;
    sbq.push_back('{"reset_rd5", 64'd0});
    sbq.push_back('{"reset_busy_vec", 64'd0});
    sbq.push_back('{"reset_dbg", 64'd0});
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[31:0], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(a_vec) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_vec, e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(a_dbg) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_dbg, e.exp); end
    tick(); rst_n = 1; dbg_id = 0; tick();
    $display("[TB] test_reset: async reset cleared reg 5, scoreboard and debug port");
  endtask

  task automatic test_x0_conflict();
    exp_t e;
    idle(); rd_id = {5'd0, 5'd0};
    w0_en = 1; w0_id = 0; w0_data = 32'h1234;
    sbq.push_back('{"x0_bypass_rd", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[31:0], e.exp); end
    tick(); idle();
    sbq.push_back('{"x0_stored_rd", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[31:0], e.exp); end
    tick();
    $display("[TB] test_x0_conflict: write to x0 ignored");
    rd_id = {5'd0, 5'd7};
    w0_en = 1; w0_id = 7; w0_data = 32'hAAAA0000;
    w1_en = 1; w1_id = 7; w1_data = 32'h00005555;
    sbq.push_back('{"conflict_bypass_a", 64'h5555});
    sbq.push_back('{"conflict_nobypass_b", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[31:0], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[31:0], e.exp); end
    tick(); idle();
    sbq.push_back('{"conflict_stored_a", 64'h5555});
    sbq.push_back('{"conflict_stored_b", 64'h5555});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[31:0], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[31:0], e.exp); end
    tick();
    $display("[TB] test_x0_conflict: w0/w1 same-id conflict resolved to w1");
  endtask

  task automatic test_bypass();
    exp_t e;
    idle(); rd_id = {5'd3, 5'd0};
    w1_en = 1; w1_id = 3; w1_data = 32'h11111111;
    tick(); idle();
    w0_en = 1; w0_id = 3; w0_data = 32'hCAFEF00D;
    sbq.push_back('{"bypass_a_rd", 64'hCAFEF00D});
    sbq.push_back('{"bypass_b_rd_old", 64'h11111111});
    sbq.push_back('{"bypass_a_busy", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_rd[63:32]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_rd[63:32], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[63:32]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[63:32], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(a_busy[1]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_busy[1], e.exp); end
    tick(); idle();
    sbq.push_back('{"bypass_b_rd_new", 64'hCAFEF00D});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[63:32]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[63:32], e.exp); end
    tick();
    w0_en = 1; w0_id = 3; w0_data = 32'h0000BEEF; sb_set = 1; sb_id = 3;
    sbq.push_back('{"bypass_set_a_busy", 64'd1});
    sbq.push_back('{"bypass_set_b_busy", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_busy[1]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_busy[1], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_busy[1]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_busy[1], e.exp); end
    tick(); idle();
    w1_en = 1; w1_id = 3; w1_data = 32'h0;
    tick(); idle();
    $display("[TB] test_bypass: same-cycle forwarding (BYPASS=1) vs stored value (BYPASS=0)");
  endtask

  task automatic test_scoreboard();
    exp_t e;
    idle(); rd_id = {5'd0, 5'd9};
    sb_set = 1; sb_id = 9;
    tick(); idle();
    sbq.push_back('{"sb_set_vec9", 64'd1});
    sbq.push_back('{"sb_set_b_busy", 64'd1});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_vec[9]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_vec[9], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_busy[0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_busy[0], e.exp); end
    tick();
    w1_en = 1; w1_id = 9; w1_data = 32'h99;
    sbq.push_back('{"sb_wb_a_busy", 64'd0});
    sbq.push_back('{"sb_wb_b_busy", 64'd1});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_busy[0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_busy[0], e.exp); end
    e = sbq.pop_front(); n_tests++;
    if (64'(b_busy[0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_busy[0], e.exp); end
    tick(); idle();
    sbq.push_back('{"sb_clr_vec9", 64'd0});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_vec[9]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_vec[9], e.exp); end
    tick();
    sb_set = 1; sb_id = 9; w0_en = 1; w0_id = 9; w0_data = 32'h77;
    tick(); idle();
    sbq.push_back('{"sb_set_beats_clr", 64'd1});
    @(negedge clk);
    e = sbq.pop_front(); n_tests++;
    if (64'(a_vec[9]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_vec[9], e.exp); end
    tick();
    $display("[TB] test_scoreboard: set, clear and set-over-clear on reg 9");
  endtask

  task automatic test_debug();
    exp_t e;
    idle(); rd_id = {5'd0, 5'd31}; dbg_id = 0;
    w0_en = 1; w0_id = 31; w0_data = 32'h0BADC0DE;
    tick(); idle(); dbg_id = 31;
    sbq.push_back('{"dbg_rd31", 64'h0BADC0DE});
    tick();
    e = sbq.pop_front(); n_tests++;
    if (64'(a_dbg) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_dbg, e.exp); end
    sbq.push_back('{"top_index_rd31", 64'h0BADC0DE});
    e = sbq.pop_front(); n_tests++;
    if (64'(b_rd[31:0]) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_rd[31:0], e.exp); end
    w0_en = 1; w0_id = 31; w0_data = 32'h12345678;
    sbq.push_back('{"dbg_no_same_cycle", 64'h0BADC0DE});
    tick(); idle();
    e = sbq.pop_front(); n_tests++;
    if (64'(a_dbg) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_dbg, e.exp); end
    sbq.push_back('{"dbg_next_cycle", 64'h12345678});
    tick(); dbg_id = 0;
    e = sbq.pop_front(); n_tests++;
    if (64'(b_dbg) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, b_dbg, e.exp); end
    sbq.push_back('{"dbg_x0", 64'd0});
    tick();
    e = sbq.pop_front(); n_tests++;
    if (64'(a_dbg) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, a_dbg, e.exp); end
    $display("[TB] test_debug: 1-cycle debug read of reg 31 and x0");
  endtask

  task automatic test_sweep();
    exp_t e;
    int   fails_before;
    logic [3:0] id;
    fails_before = n_fail;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      c_w0_en = 1'($urandom_range(0, 1)); c_w0_id = 4'($urandom_range(0, 15));
      c_w1_en = 1'($urandom_range(0, 1)); c_w1_id = 4'($urandom_range(0, 15));
      if (cyc % 5 == 0) c_w1_id = c_w0_id;
      c_w0_data = {$urandom, $urandom}; c_w1_data = {$urandom, $urandom};
      c_sb_set = 1'($urandom_range(0, 1)); c_sb_id = 4'($urandom_range(0, 15));
      c_dbg_id = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) c_rd_id[k*4 +: 4] = (cyc % 7 == k) ? 4'd15 : 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        id = c_rd_id[k*4 +: 4];
        if (id == 0) begin
          sbq.push_back('{$sformatf("sweep_rd%0d", k), 64'd0});
          sbq.push_back('{$sformatf("sweep_busy%0d", k), 64'd0});
        end else if (c_w1_en && c_w1_id == id) begin
          sbq.push_back('{$sformatf("sweep_rd%0d", k), c_w1_data});
          sbq.push_back('{$sformatf("sweep_busy%0d", k), 64'(c_sb_set && c_sb_id == id)});
        end else if (c_w0_en && c_w0_id == id) begin
          sbq.push_back('{$sformatf("sweep_rd%0d", k), c_w0_data});
          sbq.push_back('{$sformatf("sweep_busy%0d", k), 64'(c_sb_set && c_sb_id == id)});
        end else begin
          sbq.push_back('{$sformatf("sweep_rd%0d", k), m_reg[id]});
          sbq.push_back('{$sformatf("sweep_busy%0d", k), 64'(m_busy[id])});
        end
      end
      sbq.push_back('{"sweep_busy_vec", 64'(m_busy)});
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        e = sbq.pop_front(); n_tests++;
        if (c_rd[k*64 +: 64] !== e.exp) begin n_fail++; $display("FAIL %s cyc %0d: got %h want %h", e.name, cyc, c_rd[k*64 +: 64], e.exp); end
        e = sbq.pop_front(); n_tests++;
        if (64'(c_busy[k]) !== e.exp) begin n_fail++; $display("FAIL %s cyc %0d: got %h want %h", e.name, cyc, c_busy[k], e.exp); end
      end
      e = sbq.pop_front(); n_tests++;
      if (64'(c_vec) !== e.exp) begin n_fail++; $display("FAIL %s cyc %0d: got %h want %h", e.name, cyc, c_vec, e.exp); end
      sbq.push_back('{"sweep_dbg", m_reg[c_dbg_id]});
      for (int i = 1; i < 16; i++) begin
        if ((c_sb_set && c_sb_id == 4'(i)) ) m_busy[i] = 1'b1;
        else if ((c_w0_en && c_w0_id == 4'(i)) || (c_w1_en && c_w1_id == 4'(i))) m_busy[i] = 1'b0;
      end
      if (c_w0_en && c_w0_id != 0) m_reg[c_w0_id] = c_w0_data;
      if (c_w1_en && c_w1_id != 0) m_reg[c_w1_id] = c_w1_data;
      tick();
      e = sbq.pop_front(); n_tests++;
      if (c_dbg !== e.exp) begin n_fail++; $display("FAIL %s cyc %0d: got %h want %h", e.name, cyc, c_dbg, e.exp); end
    end
    $display("[TB] test_sweep: 1000 random cycles on 16x64 NR=3, %0d new failures", n_fail - fails_before);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; idle(); rd_id = 0; dbg_id = 0;
    c_rd_id = 0; c_w0_en = 0; c_w1_en = 0; c_sb_set = 0;
    c_w0_id = 0; c_w1_id = 0; c_sb_id = 0; c_dbg_id = 0;
    c_w0_data = 0; c_w1_data = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    test_reset();
    test_x0_conflict();
    test_bypass();
    test_scoreboard();
    test_debug();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
